// File: rtl/ysyx_22050598_trap_ctrl_pkg.sv
// Shared constants for the ecall/mret trap sequencer: default widths, one-hot state codes
// and trap kind.
package ysyx_22050598_trap_ctrl_pkg;

  localparam int unsigned TrapXlen = 64;
  localparam int unsigned TrapCntW = 16;

  localparam logic [2:0] TrapIdle  = 3'b001;
  localparam logic [2:0] TrapIssue = 3'b010;
  localparam logic [2:0] TrapRedir = 3'b100;

  typedef enum logic {
    TrapEcall = 1'b0,
    TrapMret  = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/ysyx_22050598_trap_ctrl.sv
// Ecall/mret sequencer between EX and the CSR file: strobes the CSR file, captures the
// returned target PC and redirects IF over a valid/ready handshake.
module ysyx_22050598_trap_ctrl
  import ysyx_22050598_trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = TrapXlen,
  parameter int unsigned CNT_W = TrapCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid_i,
  input  logic             ex_inst_is_ecall_i,
  input  logic             ex_inst_is_mret_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  csr_rd_pc_data_i,
  input  logic             if_redirect_ready_i,
  output logic             csr_ecall_o,
  output logic             csr_mret_o,
  output logic [XLEN-1:0]  csr_ecall_pc_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] trap_cnt_o
);

  localparam logic [XLEN-1:0] AlignMask = ~{{(XLEN-2){1'b0}}, 2'b11};

  logic [2:0]       state_q, state_d;
  trap_kind_e       kind_q, kind_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             in_issue, in_redir;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    pc_d     = pc_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      TrapIdle: begin
        if (ex_valid_i && (ex_inst_is_ecall_i || ex_inst_is_mret_i)) begin
          state_d = TrapIssue;
          kind_d  = ex_inst_is_ecall_i ? TrapEcall : TrapMret;
          pc_d    = ex_pc_i;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      TrapIssue: begin
        // CSR data is still the pre-update value here (mtvec or old mepc).
        target_d = csr_rd_pc_data_i & AlignMask;
        state_d  = TrapRedir;
      end
      TrapRedir: begin
        if (if_redirect_ready_i) state_d = TrapIdle;
      end
      default: state_d = TrapIdle;
    endcase
  end

  assign stall_d = (state_d != TrapIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TrapIdle;
      kind_q   <= TrapEcall;
      pc_q     <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    in_issue         = (state_q == TrapIssue);
    in_redir         = (state_q == TrapRedir);
    csr_ecall_o      = in_issue && (kind_q == TrapEcall);
    csr_mret_o       = in_issue && (kind_q == TrapMret);
    csr_ecall_pc_o   = csr_ecall_o ? pc_q : '0;
    flush_o          = in_issue || in_redir;
    stall_o          = stall_q;
    redirect_valid_o = in_redir;
    redirect_pc_o    = in_redir ? target_q : '0;
    trap_cnt_o       = cnt_q;
  end

endmodule
